spi_slave_if: RTL and testbench

Serial front end for the single-port SPI RAM subsystem: deserializes 10-bit MSB-first SPI frames from MOSI into parallel command words (`rx_data`/`rx_valid`) for the downstream RAM stage. On read-data frames it also captures the RAM's 8-bit response (`tx_data`/`tx_valid`) and shifts it out on MISO. `clk` is the SPI serial clock; all sampling and driving happens on its rising edge.

---
 rtl/spi_slave_if.sv | 152 +++++++++++++++
 tb/tb_spi_slave_if.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front end for the SPI RAM; deserializes 10-bit MSB-first MOSI frames into
//   rx_data/rx_valid, and on read-data frames shifts the RAM's tx_data out on MISO MSB first.
// Latency: rx_valid the cycle after the edge sampling bit 0; MISO[7] the edge after tx_valid is seen.
// Backpressure: none; the slave waits indefinitely for tx_valid while SS_n=0, SS_n=1 aborts any frame.
// Ports: clk (SPI clock, rising edge), rst_n (async active-low), SS_n, MOSI, MISO,
//   rx_data/rx_valid (to RAM), tx_data/tx_valid (from RAM).
// Optional: define SPI_SLAVE_SVA_EN to compile embedded assertions and state-transition covers.
module spi_slave_if #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    localparam int CNT_W  = $clog2(FRAME_W + 1);
    localparam int TCNT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_W);      // frame complete
    localparam logic [CNT_W-1:0]  BIT0_CNT = CNT_W'(FRAME_W - 1);  // this edge samples bit 0
    localparam logic [TCNT_W-1:0] TX_DONE  = TCNT_W'(DATA_W);

    // One-hot encoding keeps the state register trivially checkable for legality.
    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        CHK_CMD   = 5'b00010,
        WRITE     = 5'b00100,
        READ_ADD  = 5'b01000,
        READ_DATA = 5'b10000
    } state_t;

    state_t state_q, state_nxt;

    // Only FRAME_W-1 bits are buffered: the final bit goes straight from MOSI into rx_data.
    logic [FRAME_W-2:0] rx_shift_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [DATA_W-2:0]  tx_shift_q;
    logic [TCNT_W-1:0]  tx_cnt_q;
    logic               tx_started_q;
    logic               rd_addr_seen_q;

    logic in_body;
    logic frame_done;

    assign in_body    = state_q inside {WRITE, READ_ADD, READ_DATA};
    assign frame_done = (bit_cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (SS_n) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_nxt = CHK_CMD;
                // Bit 9 picks the body state; a read is an address phase unless one is pending.
                CHK_CMD: state_nxt = !MOSI ? WRITE : (rd_addr_seen_q ? READ_DATA : READ_ADD);
                WRITE, READ_ADD, READ_DATA: state_nxt = state_q;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift_q     <= '0;
            bit_cnt_q      <= '0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_shift_q     <= '0;
            tx_cnt_q       <= '0;
            tx_started_q   <= 1'b0;
            MISO           <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                // Idle or abort: drop any partial frame/transmission, keep rx_data and rd_addr_seen.
                bit_cnt_q    <= '0;
                tx_cnt_q     <= '0;
                tx_started_q <= 1'b0;
                MISO         <= 1'b0;
            end else begin
                if (state_q == CHK_CMD) begin
                    rx_shift_q <= {rx_shift_q[FRAME_W-3:0], MOSI};
                    bit_cnt_q  <= CNT_W'(1);
                end else if (in_body && !frame_done) begin
                    rx_shift_q <= {rx_shift_q[FRAME_W-3:0], MOSI};
                    bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == BIT0_CNT) begin
                        rx_data  <= {rx_shift_q, MOSI};
                        rx_valid <= 1'b1;
                        if (state_q == READ_ADD)       rd_addr_seen_q <= 1'b1;
                        else if (state_q == READ_DATA) rd_addr_seen_q <= 1'b0;
                    end
                end

                // Read-data return: one burst per frame, later tx_valid cycles are ignored.
                if (state_q == READ_DATA && frame_done) begin
                    if (!tx_started_q) begin
                        if (tx_valid) begin
                            MISO         <= tx_data[DATA_W-1];
                            tx_shift_q   <= tx_data[DATA_W-2:0];
                            tx_cnt_q     <= TCNT_W'(1);
                            tx_started_q <= 1'b1;
                        end
                    end else if (tx_cnt_q != TX_DONE) begin
                        MISO       <= tx_shift_q[DATA_W-2];
                        tx_shift_q <= {tx_shift_q[DATA_W-3:0], 1'b0};
                        tx_cnt_q   <= tx_cnt_q + TCNT_W'(1);
                    end else begin
                        MISO <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef SPI_SLAVE_SVA_EN
    a_rx_valid_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        rx_valid |=> !rx_valid);
    a_rx_valid_src: assert property (@(posedge clk) disable iff (!rst_n)
        rx_valid |-> (in_body && bit_cnt_q == LAST_CNT));
    a_idle_miso: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE) |-> !MISO);
    a_reset_outs: assert property (@(posedge clk)
        !rst_n |-> (!MISO && !rx_valid && rx_data == '0));
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot(state_q));

    c_idle_chk:  cover property (@(posedge clk) state_q == IDLE ##1 state_q == CHK_CMD);
    c_chk_idle:  cover property (@(posedge clk) state_q == CHK_CMD ##1 state_q == IDLE);
    c_chk_wr:    cover property (@(posedge clk) state_q == CHK_CMD ##1 state_q == WRITE);
    c_chk_radd:  cover property (@(posedge clk) state_q == CHK_CMD ##1 state_q == READ_ADD);
    c_chk_rdat:  cover property (@(posedge clk) state_q == CHK_CMD ##1 state_q == READ_DATA);
    c_wr_idle:   cover property (@(posedge clk) state_q == WRITE ##1 state_q == IDLE);
    c_radd_idle: cover property (@(posedge clk) state_q == READ_ADD ##1 state_q == IDLE);
    c_rdat_idle: cover property (@(posedge clk) state_q == READ_DATA ##1 state_q == IDLE);
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed plus randomized frames for spi_slave_if, checked against a frame-level model.
// Latency: inputs driven and outputs sampled on the falling edge of clk.
// Backpressure: tx_valid delay and hold length are chosen per frame.
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Frame-level model: last delivered word and whether a read address is pending.
    logic [9:0] rx_data_m   = '0;
    bit         rd_seen_m   = 1'b0;

    always #5 clk = ~clk;

    spi_slave_if #(.FRAME_W(10), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send one frame. nbits<10 aborts after that many bits. After completion the RAM raises
    // tx_valid d cycles after the word is registered, for hold cycles. mode 1 = SS_n abort,
    // mode 2 = reset, applied at post-frame cycle abort_c.
    task automatic frame(input logic [9:0] f, input int nbits, input int d, input int hold,
                         input logic [7:0] txd, input int mode, input int abort_c);
        bit         is_rd;
        logic [7:0] exp_miso;
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'($urandom);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            chk("body_rx_valid", rx_valid, 0);
            chk("body_miso", MISO, 0);
            MOSI = f[9-i];
        end
        if (nbits < 10) begin
            @(negedge clk);
            chk("pre_abort_rx_valid", rx_valid, 0);
            SS_n = 1'b1;
            @(negedge clk);
            chk("abort_rx_valid", rx_valid, 0);
            chk("abort_rx_data", rx_data, rx_data_m);
            chk("abort_miso", MISO, 0);
            return;
        end
        @(negedge clk);
        chk("rx_valid", rx_valid, 1);
        chk("rx_data", rx_data, f);
        chk("done_miso", MISO, 0);
        is_rd     = f[9] && rd_seen_m;
        rx_data_m = f;
        if (f[9]) rd_seen_m = !rd_seen_m;
        for (int c = 0; c <= d + 11; c++) begin
            @(negedge clk);
            exp_miso = '0;
            if (is_rd && c >= d + 1 && c <= d + 8) exp_miso[0] = txd[8 + d - c];
            chk("tx_miso", MISO, exp_miso);
            chk("tx_rx_valid", rx_valid, 0);
            if (mode == 1 && c == abort_c) begin
                SS_n     = 1'b1;
                tx_valid = 1'b0;
                @(negedge clk);
                chk("ss_abort_miso", MISO, 0);
                chk("ss_abort_rx_data", rx_data, rx_data_m);
                return;
            end
            if (mode == 2 && c == abort_c) begin
                rst_n = 1'b0;
                #1;
                chk("rst_miso", MISO, 0);
                chk("rst_rx_valid", rx_valid, 0);
                chk("rst_rx_data", rx_data, 0);
                rx_data_m = '0;
                rd_seen_m = 1'b0;
                SS_n      = 1'b1;
                tx_valid  = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            tx_valid = (c >= d && c < d + hold);
            tx_data  = tx_valid ? txd : 8'($urandom);
            MOSI     = 1'($urandom);
        end
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        chk("end_miso", MISO, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (2) @(negedge clk);
        chk("reset_miso", MISO, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 0);
        rst_n = 1'b1;

        // Write address, then write data, then address + data read.
        frame(10'h0A5, 10, 0, 1, 8'h00, 0, 0);
        frame(10'h13C, 10, 0, 1, 8'h00, 0, 0);
        frame(10'h2A5, 10, 0, 1, 8'h00, 0, 0);
        frame(10'h300, 10, 0, 1, 8'h3C, 0, 0);
        // tx_valid held 5 cycles with a late start: single burst, no reload.
        frame(10'h2C3, 10, 0, 1, 8'h00, 0, 0);
        frame(10'h3C3, 10, 2, 5, 8'hA6, 0, 0);
        // Abort after 6 bits of 0x1FF.
        frame(10'h1FF, 6, 0, 1, 8'h00, 0, 0);
        // Two read frames without a prior address phase: READ_ADD then READ_DATA.
        frame(10'h3FF, 10, 0, 1, 8'h55, 0, 0);
        frame(10'h201, 10, 1, 2, 8'h81, 0, 0);
        // Reset mid transmission, then a fresh read pair from IDLE.
        frame(10'h211, 10, 0, 1, 8'h00, 0, 0);
        frame(10'h322, 10, 1, 1, 8'hF0, 2, 5);
        frame(10'h233, 10, 0, 1, 8'h00, 0, 0);
        frame(10'h344, 10, 0, 3, 8'h5A, 0, 0);
        // SS_n abort mid transmission.
        frame(10'h255, 10, 0, 1, 8'h00, 0, 0);
        frame(10'h366, 10, 0, 1, 8'hC3, 1, 4);
        frame(10'h077, 10, 0, 1, 8'h99, 0, 0);

        for (int k = 0; k < 30; k++) begin
            logic [9:0] f;
            int nb;
            f  = 10'($urandom);
            nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 9)) : 10;
            frame(f, nb, int'($urandom_range(0, 4)), int'($urandom_range(1, 5)),
                  8'($urandom), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
